// File: rtl/cascade_cache_streamer_if.sv
// Bus interface for cascade_cache_streamer: burst request, cache read port,
// output stream and status. The streamer connects through the slave modport;
// the agent that issues bursts, models the cache and consumes the stream
// connects through the master modport.
interface cascade_cache_streamer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_SIZE  = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [WORD_SIZE-1:0]  q;
  logic [WORD_SIZE-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport master (
    output start, base_addr, count, q, out_ready,
    input  raddr, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    input  start, base_addr, count, q, out_ready,
    output raddr, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/cascade_cache_streamer.sv
// cascade_cache_streamer: reads a burst of count words starting at base_addr
// from the cascade cache and streams them out over a valid/ready port.
// raddr is a register; the cache turns it into q combinationally, so each
// read is in flight for exactly one cycle before it lands in a 2-entry FIFO
// whose head drives the stream. Reads are throttled so that buffered words
// plus in-flight reads never exceed two after any clock edge.
// Optional feature: define CASCADE_CACHE_STREAMER_ABORT_EN to add an abort
// input that cancels the current burst.
module cascade_cache_streamer #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_SIZE  = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CASCADE_CACHE_STREAMER_ABORT_EN
  input  logic abort,
`endif
  cascade_cache_streamer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;         // next address to read
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH:0]   rd_left_q, rd_left_d;   // reads still to issue
  logic                  rd_q, rd_d;             // a read is in flight
  logic                  rd_last_q, rd_last_d;   // the in-flight read is the final one
  logic [1:0]            occ_q, occ_d;           // FIFO occupancy
  logic [WORD_SIZE-1:0]  ent0_q, ent0_d, ent1_q, ent1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  pop;
  logic [2:0]            load;
  logic                  to_head;

  // Next-state, read issue and FIFO update.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    raddr_d   = raddr_q;
    rd_left_d = rd_left_q;
    rd_d      = 1'b0;
    rd_last_d = 1'b0;
    occ_d     = occ_q;
    ent0_d    = ent0_q;
    ent1_d    = ent1_q;
    last0_d   = last0_q;
    last1_d   = last1_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    pop  = (occ_q != 2'd0) && bus.out_ready;
    load = {1'b0, occ_q} + {2'b00, rd_q} - {2'b00, pop};

    // FIFO: a pop shifts the tail forward; the in-flight word lands in the
    // first slot left free after that shift.
    occ_d   = occ_q + {1'b0, rd_q} - {1'b0, pop};
    to_head = (occ_q == 2'd0) || ((occ_q == 2'd1) && pop);
    if (pop) begin
      ent0_d  = ent1_q;
      last0_d = last1_q;
    end
    if (rd_q) begin
      if (to_head) begin
        ent0_d  = bus.q;
        last0_d = rd_last_q;
      end else begin
        ent1_d  = bus.q;
        last1_d = rd_last_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = RUN;
            addr_d    = bus.base_addr;
            rd_left_d = bus.count;
            busy_d    = 1'b1;
          end
        end
      end
      RUN: begin
        if (load < 3'd2) begin
          raddr_d   = addr_q;
          addr_d    = addr_q + 1'b1;
          rd_left_d = rd_left_q - 1'b1;
          rd_d      = 1'b1;
          rd_last_d = (rd_left_q == CNT_ONE);
          if (rd_left_q == CNT_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last0_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef CASCADE_CACHE_STREAMER_ABORT_EN
    // Abort wins over everything above: no new read, buffered and in-flight
    // words are dropped, and the burst ends with a done pulse.
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      raddr_d   = raddr_q;
      rd_d      = 1'b0;
      rd_last_d = 1'b0;
      occ_d     = 2'd0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      raddr_q   <= '0;
      rd_left_q <= '0;
      rd_q      <= 1'b0;
      rd_last_q <= 1'b0;
      occ_q     <= 2'd0;
      // NOTE: the FIFO storage is only two words and the head entry drives
      // out_data directly, so it is reset like any other register.
      ent0_q    <= '0;
      ent1_q    <= '0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      addr_q    <= addr_d;
      raddr_q   <= raddr_d;
      rd_left_q <= rd_left_d;
      rd_q      <= rd_d;
      rd_last_q <= rd_last_d;
      occ_q     <= occ_d;
      ent0_q    <= ent0_d;
      ent1_q    <= ent1_d;
      last0_q   <= last0_d;
      last1_q   <= last1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Outputs come straight from registers.
  assign bus.raddr     = raddr_q;
  assign bus.out_data  = ent0_q;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_last  = (occ_q != 2'd0) && last0_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
